char_pixel_shifter: RTL and testbench

- Parametrised successor to the fixed combinational character ROM.
- Accepts {character code, glyph row, attributes} over a valid/ready handshake and looks up the glyph row in a registered ROM.
- Serialises the row MSB-first as a pixel stream paced by the VGA pixel enable, with inverse video, horizontal pixel repetition and underrun detection.
- Sits between the text-mode video RAM fetch logic and the VGA colour output.

---
 rtl/char_pixel_shifter_pkg.sv | 96 +++++++++
 rtl/char_pixel_shifter_if.sv | 19 +
 rtl/char_pixel_shifter_glyph_rom.sv | 26 ++
 rtl/char_pixel_shifter.sv | 115 +++++++++++
 tb/tb_char_pixel_shifter.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/char_pixel_shifter_pkg.sv
// Shared definitions for the character pixel shifter: default widths, the
// glyph row type and the 64-glyph font. Glyph order is @,A..Z,[,\,],^,_,
// space, punctuation, 0..9 and :;<=>? (codes 0..63). Each glyph is 5x7,
// occupies cell rows 3..9, and sits in bits 5..1 of an 8-pixel row so that
// bit 0 and bits 7..6 give inter-character spacing.
package char_pixel_pkg;

  localparam int unsigned CODE_BITS_DEF = 6;
  localparam int unsigned ROW_BITS_DEF  = 4;
  localparam int unsigned GLYPH_W_DEF   = 8;
  localparam int unsigned UL_ROW_DEF    = 10;

  localparam int unsigned FONT_GLYPHS = 64;
  localparam int unsigned FONT_ROWS   = 7;
  localparam int unsigned FONT_TOP    = 3;

  typedef logic [GLYPH_W_DEF-1:0] glyph_row_t;

  // 5-bit rows, bit 4 is the leftmost pixel.
  localparam logic [4:0] FONT [0:FONT_GLYPHS-1][0:FONT_ROWS-1] = '{
    '{5'h0E, 5'h11, 5'h17, 5'h15, 5'h17, 5'h10, 5'h0F},  // @
    '{5'h04, 5'h0A, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11},  // A
    '{5'h1E, 5'h11, 5'h11, 5'h1E, 5'h11, 5'h11, 5'h1E},  // B
    '{5'h0E, 5'h11, 5'h10, 5'h10, 5'h10, 5'h11, 5'h0E},  // C
    '{5'h1C, 5'h12, 5'h11, 5'h11, 5'h11, 5'h12, 5'h1C},  // D
    '{5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h1F},  // E
    '{5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h10},  // F
    '{5'h0E, 5'h11, 5'h10, 5'h17, 5'h11, 5'h11, 5'h0F},  // G
    '{5'h11, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11, 5'h11},  // H
    '{5'h0E, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E},  // I
    '{5'h07, 5'h02, 5'h02, 5'h02, 5'h02, 5'h12, 5'h0C},  // J
    '{5'h11, 5'h12, 5'h14, 5'h18, 5'h14, 5'h12, 5'h11},  // K
    '{5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h1F},  // L
    '{5'h11, 5'h1B, 5'h15, 5'h15, 5'h11, 5'h11, 5'h11},  // M
    '{5'h11, 5'h11, 5'h19, 5'h15, 5'h13, 5'h11, 5'h11},  // N
    '{5'h0E, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0E},  // O
    '{5'h1E, 5'h11, 5'h11, 5'h1E, 5'h10, 5'h10, 5'h10},  // P
    '{5'h0E, 5'h11, 5'h11, 5'h11, 5'h15, 5'h12, 5'h0D},  // Q
    '{5'h1E, 5'h11, 5'h11, 5'h1E, 5'h14, 5'h12, 5'h11},  // R
    '{5'h0F, 5'h10, 5'h10, 5'h0E, 5'h01, 5'h01, 5'h1E},  // S
    '{5'h1F, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04},  // T
    '{5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0E},  // U
    '{5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0A, 5'h04},  // V
    '{5'h11, 5'h11, 5'h11, 5'h15, 5'h15, 5'h15, 5'h0A},  // W
    '{5'h11, 5'h11, 5'h0A, 5'h04, 5'h0A, 5'h11, 5'h11},  // X
    '{5'h11, 5'h11, 5'h11, 5'h0A, 5'h04, 5'h04, 5'h04},  // Y
    '{5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h1F},  // Z
    '{5'h0E, 5'h08, 5'h08, 5'h08, 5'h08, 5'h08, 5'h0E},  // [
    '{5'h00, 5'h10, 5'h08, 5'h04, 5'h02, 5'h01, 5'h00},  // backslash
    '{5'h0E, 5'h02, 5'h02, 5'h02, 5'h02, 5'h02, 5'h0E},  // ]
    '{5'h04, 5'h0A, 5'h11, 5'h00, 5'h00, 5'h00, 5'h00},  // ^
    '{5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h1F},  // _
    '{5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00},  // space
    '{5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h00, 5'h04},  // !
    '{5'h0A, 5'h0A, 5'h0A, 5'h00, 5'h00, 5'h00, 5'h00},  // "
    '{5'h0A, 5'h0A, 5'h1F, 5'h0A, 5'h1F, 5'h0A, 5'h0A},  // #
    '{5'h04, 5'h0F, 5'h14, 5'h0E, 5'h05, 5'h1E, 5'h04},  // $
    '{5'h18, 5'h19, 5'h02, 5'h04, 5'h08, 5'h13, 5'h03},  // %
    '{5'h0C, 5'h12, 5'h14, 5'h08, 5'h15, 5'h12, 5'h0D},  // &
    '{5'h0C, 5'h04, 5'h08, 5'h00, 5'h00, 5'h00, 5'h00},  // '
    '{5'h02, 5'h04, 5'h08, 5'h08, 5'h08, 5'h04, 5'h02},  // (
    '{5'h08, 5'h04, 5'h02, 5'h02, 5'h02, 5'h04, 5'h08},  // )
    '{5'h00, 5'h04, 5'h15, 5'h0E, 5'h15, 5'h04, 5'h00},  // *
    '{5'h00, 5'h04, 5'h04, 5'h1F, 5'h04, 5'h04, 5'h00},  // +
    '{5'h00, 5'h00, 5'h00, 5'h00, 5'h0C, 5'h04, 5'h08},  // ,
    '{5'h00, 5'h00, 5'h00, 5'h1F, 5'h00, 5'h00, 5'h00},  // -
    '{5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h0C, 5'h0C},  // .
    '{5'h00, 5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h00},  // /
    '{5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E},  // 0
    '{5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E},  // 1
    '{5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F},  // 2
    '{5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E},  // 3
    '{5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02},  // 4
    '{5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E},  // 5
    '{5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E},  // 6
    '{5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08},  // 7
    '{5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E},  // 8
    '{5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C},  // 9
    '{5'h00, 5'h0C, 5'h0C, 5'h00, 5'h0C, 5'h0C, 5'h00},  // :
    '{5'h00, 5'h0C, 5'h0C, 5'h00, 5'h0C, 5'h04, 5'h08},  // ;
    '{5'h02, 5'h04, 5'h08, 5'h10, 5'h08, 5'h04, 5'h02},  // <
    '{5'h00, 5'h00, 5'h1F, 5'h00, 5'h1F, 5'h00, 5'h00},  // =
    '{5'h08, 5'h04, 5'h02, 5'h01, 5'h02, 5'h04, 5'h08},  // >
    '{5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h00, 5'h04}   // ?
  };

  // Full cell row for (code,row); anything outside the font is background.
  function automatic glyph_row_t font_row(input int unsigned code, input int unsigned row);
    glyph_row_t r;
    r = '0;
    if (code < FONT_GLYPHS && row >= FONT_TOP && row < FONT_TOP + FONT_ROWS)
      r = {2'b00, FONT[6'(code)][3'(row - FONT_TOP)], 1'b0};
    return r;
  endfunction

endpackage

// File: rtl/char_pixel_shifter_if.sv
// Character request channel from the text-mode fetch logic.
// Signals: in_valid/in_ready handshake, in_code, in_row, in_inverse, in_uline.
// master = fetch side (drives the request), slave = pixel shifter.
interface char_pixel_shifter_if
  import char_pixel_pkg::*;
#(
  parameter int unsigned CODE_BITS = CODE_BITS_DEF,
  parameter int unsigned ROW_BITS  = ROW_BITS_DEF
);
  logic                 in_valid;
  logic                 in_ready;
  logic [CODE_BITS-1:0] in_code;
  logic [ROW_BITS-1:0]  in_row;
  logic                 in_inverse;
  logic                 in_uline;

  modport master (output in_valid, in_code, in_row, in_inverse, in_uline, input in_ready);
  modport slave  (input in_valid, in_code, in_row, in_inverse, in_uline, output in_ready);
endinterface

// File: rtl/char_pixel_shifter_glyph_rom.sv
// glyph_rom: registered font lookup, one-cycle latency, address {code,row}.
// Ports: clk, en (capture enable), addr, data (glyph row, MSB = leftmost pixel).
// Codes/rows without a glyph read as zero. Data is not reset; the consumer
// qualifies it with its own valid flag.
module glyph_rom
  import char_pixel_pkg::*;
#(
  parameter int unsigned CODE_BITS = CODE_BITS_DEF,
  parameter int unsigned ROW_BITS  = ROW_BITS_DEF,
  parameter int unsigned GLYPH_W   = GLYPH_W_DEF
) (
  input  logic                          clk,
  input  logic                          en,
  input  logic [CODE_BITS+ROW_BITS-1:0] addr,
  output logic [GLYPH_W-1:0]            data
);
  logic [CODE_BITS-1:0] code;
  logic [ROW_BITS-1:0]  row;

  assign code = addr[CODE_BITS+ROW_BITS-1:ROW_BITS];
  assign row  = addr[ROW_BITS-1:0];

  always_ff @(posedge clk) begin
    if (en) data <= GLYPH_W'(font_row(32'(code), 32'(row)));
  end
endmodule

// File: rtl/char_pixel_shifter.sv
// char_pixel_shifter: takes {code,row,attributes} requests, looks the glyph
// row up in glyph_rom (stage S1) and serialises it MSB-first, one pixel per
// PIX_REP pix_en strobes, with inverse video and sticky underrun detection.
// Ports: clk, reset (sync, active-high), req (char_pixel_shifter_if.slave),
//        pix_en (VGA pixel enable), pix_out, pix_valid, underrun.
// Optional: define CHAR_PIXEL_UNDERLINE_EN to add parameter UL_ROW and force
// the underline row to all-foreground when in_uline is set.
module char_pixel_shifter
  import char_pixel_pkg::*;
#(
  parameter int unsigned CODE_BITS = CODE_BITS_DEF,
  parameter int unsigned ROW_BITS  = ROW_BITS_DEF,
  parameter int unsigned GLYPH_W   = GLYPH_W_DEF,
  parameter int unsigned PIX_REP   = 1
`ifdef CHAR_PIXEL_UNDERLINE_EN
  , parameter int unsigned UL_ROW  = UL_ROW_DEF
`endif
) (
  input  logic                clk,
  input  logic                reset,
  char_pixel_shifter_if.slave req,
  input  logic                pix_en,
  output logic                pix_out,
  output logic                pix_valid,
  output logic                underrun
);
  localparam int unsigned CNT_W = $clog2(GLYPH_W + 1);
  localparam int unsigned REP_W = $clog2(PIX_REP) + 1;

  logic               s1_valid;
  logic               s1_inv;
  logic [GLYPH_W-1:0] rom_data;
  logic [GLYPH_W-1:0] load_row_c;
  logic [GLYPH_W-1:0] shreg;
  logic [CNT_W-1:0]   pix_cnt;
  logic [REP_W-1:0]   rep_cnt;
  logic               inv;
  logic               accept_c;
  logic               load_c;
  logic               rep_last_c;

  glyph_rom #(
    .CODE_BITS (CODE_BITS),
    .ROW_BITS  (ROW_BITS),
    .GLYPH_W   (GLYPH_W)
  ) u_rom (
    .clk  (clk),
    .en   (accept_c),
    .addr ({req.in_code, req.in_row}),
    .data (rom_data)
  );

  // Load when the shifter is idle, or on the strobe that retires its last pixel.
  assign rep_last_c   = (rep_cnt == REP_W'(PIX_REP - 1));
  assign load_c       = s1_valid & ((pix_cnt == '0) |
                                    (pix_en & (pix_cnt == CNT_W'(1)) & rep_last_c));
  assign req.in_ready = ~s1_valid | load_c;
  assign accept_c     = req.in_valid & req.in_ready;

`ifdef CHAR_PIXEL_UNDERLINE_EN
  // Underline decision is made at accept time so only one flag is carried.
  logic s1_ul;

  always_ff @(posedge clk) begin
    if (reset)         s1_ul <= 1'b0;
    else if (accept_c) s1_ul <= req.in_uline & (req.in_row == ROW_BITS'(UL_ROW));
  end

  assign load_row_c = s1_ul ? '1 : rom_data;
`else
  logic unused_uline;
  assign unused_uline = req.in_uline;
  assign load_row_c   = rom_data;
`endif

  // S1 occupancy, shifter and underrun state.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_inv   <= 1'b0;
      shreg    <= '0;
      pix_cnt  <= '0;
      rep_cnt  <= '0;
      inv      <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (accept_c) begin
        s1_valid <= 1'b1;
        s1_inv   <= req.in_inverse;
      end else if (load_c) begin
        s1_valid <= 1'b0;
      end

      if (load_c) begin
        shreg   <= load_row_c;
        pix_cnt <= CNT_W'(GLYPH_W);
        rep_cnt <= '0;
        inv     <= s1_inv;
      end else if (pix_en && pix_cnt != '0) begin
        if (rep_last_c) begin
          shreg   <= {shreg[GLYPH_W-2:0], 1'b0};
          pix_cnt <= pix_cnt - CNT_W'(1);
          rep_cnt <= '0;
        end else begin
          rep_cnt <= rep_cnt + REP_W'(1);
        end
      end

      if (pix_en && pix_cnt == '0 && !load_c) underrun <= 1'b1;
    end
  end

  assign pix_valid = (pix_cnt != '0);
  assign pix_out   = pix_valid & (shreg[GLYPH_W-1] ^ inv);
endmodule

// File: tb/tb_char_pixel_shifter.sv
// Bench for char_pixel_shifter: two instances (PIX_REP=1 and PIX_REP=2),
// directed scenarios with literal expected rows, then random traffic checked
// by per-instance expected-pixel queues built from the font table.
module tb_char_pixel_shifter;
  import char_pixel_pkg::*;

`ifdef CHAR_PIXEL_UNDERLINE_EN
  localparam bit UL_ON = 1'b1;
`else
  localparam bit UL_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  char_pixel_shifter_if #(.CODE_BITS(6), .ROW_BITS(4)) i1 ();
  char_pixel_shifter_if #(.CODE_BITS(6), .ROW_BITS(4)) i2 ();

  logic pe1, po1, pv1, ur1;
  logic pe2, po2, pv2, ur2;

  char_pixel_shifter #(.PIX_REP(1)) dut1 (
    .clk (clk), .reset (reset), .req (i1),
    .pix_en (pe1), .pix_out (po1), .pix_valid (pv1), .underrun (ur1)
  );

  char_pixel_shifter #(.PIX_REP(2)) dut2 (
    .clk (clk), .reset (reset), .req (i2),
    .pix_en (pe2), .pix_out (po2), .pix_valid (pv2), .underrun (ur2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected on-screen row: 5x7 glyphs at cell rows 3..9, columns 5..1.
  function automatic logic [7:0] ref_row(input int code, input int row, input bit inv, input bit ul);
    logic [7:0] r;
    r = 8'h00;
    if (row >= 3 && row <= 9) r = {2'b00, FONT[6'(code)][3'(row - 3)], 1'b0};
    if (UL_ON && ul && row == 10) r = 8'hFF;
    if (inv) r = ~r;
    return r;
  endfunction

  bit q1[$];
  bit q2[$];

  // Scoreboards: every accepted request queues its pixels, every strobe on a
  // valid pixel must match the head of the queue.
  always @(negedge clk) begin : mon1
    logic [7:0] r;
    if (reset) q1.delete();
    else begin
      if (pe1 && pv1) begin
        chk("dut1 pixel expected", 32'(q1.size() != 0), 1);
        if (q1.size() != 0) chk("dut1 pixel", 32'(po1), 32'(q1.pop_front()));
      end
      if (i1.in_valid && i1.in_ready) begin
        r = ref_row(int'(i1.in_code), int'(i1.in_row), i1.in_inverse, i1.in_uline);
        for (int b = 7; b >= 0; b--) q1.push_back(r[b]);
      end
    end
  end

  always @(negedge clk) begin : mon2
    logic [7:0] r;
    if (reset) q2.delete();
    else begin
      if (pe2 && pv2) begin
        chk("dut2 pixel expected", 32'(q2.size() != 0), 1);
        if (q2.size() != 0) chk("dut2 pixel", 32'(po2), 32'(q2.pop_front()));
      end
      if (i2.in_valid && i2.in_ready) begin
        r = ref_row(int'(i2.in_code), int'(i2.in_row), i2.in_inverse, i2.in_uline);
        for (int b = 7; b >= 0; b--) begin
          q2.push_back(r[b]);
          q2.push_back(r[b]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pe1 = 1'b0; pe2 = 1'b0;
    i1.in_valid = 1'b0; i2.in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // One request on dut1 from idle; pix_en only once S1 is full.
  task automatic run_char(input int code, input int row, input bit inv, input bit ul,
                          input logic [7:0] exp, input string tag);
    i1.in_valid = 1'b1; i1.in_code = 6'(code); i1.in_row = 4'(row);
    i1.in_inverse = inv; i1.in_uline = ul; pe1 = 1'b0;
    chk({tag, " ready"}, 32'(i1.in_ready), 1);
    tick();
    i1.in_valid = 1'b0; pe1 = 1'b1;
    chk({tag, " no pixel at accept+1"}, 32'(pv1), 0);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk({tag, " valid"}, 32'(pv1), 1);
      chk({tag, " pixel"}, 32'(po1), 32'(exp[7-i]));
      tick();
    end
    pe1 = 1'b0;
    chk({tag, " valid after row"}, 32'(pv1), 0);
    chk({tag, " underrun"}, 32'(ur1), 0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] exp16;
    int n;
    reset = 1'b0;
    pe1 = 1'b0; pe2 = 1'b0;
    i1.in_valid = 1'b0; i1.in_code = '0; i1.in_row = '0; i1.in_inverse = 1'b0; i1.in_uline = 1'b0;
    i2.in_valid = 1'b0; i2.in_code = '0; i2.in_row = '0; i2.in_inverse = 1'b0; i2.in_uline = 1'b0;
    do_reset();

    // Reset state.
    chk("reset in_ready", 32'(i1.in_ready), 1);
    chk("reset pix_out", 32'(po1), 0);
    chk("reset pix_valid", 32'(pv1), 0);
    chk("reset underrun", 32'(ur1), 0);
    chk("reset dut2 pix_valid", 32'(pv2), 0);

    // Single characters, normal and inverse.
    run_char(1, 3, 1'b0, 1'b0, 8'b0000_1000, "A row3");
    run_char(1, 3, 1'b1, 1'b0, 8'b1111_0111, "A row3 inv");
    run_char(2, 3, 1'b0, 1'b0, 8'b0011_1100, "B row3");

    // Back-to-back with in_valid held: 16 contiguous pixels.
    i1.in_valid = 1'b1; i1.in_code = 6'd1; i1.in_row = 4'd3; i1.in_inverse = 1'b0; pe1 = 1'b0;
    tick();
    i1.in_code = 6'd2; pe1 = 1'b1;
    chk("b2b second accept ready", 32'(i1.in_ready), 1);
    tick();
    i1.in_valid = 1'b0;
    chk("b2b ready while S1 full", 32'(i1.in_ready), 0);
    exp16 = 16'b0000_1000_0011_1100;
    for (int i = 0; i < 16; i++) begin
      chk("b2b valid", 32'(pv1), 1);
      chk("b2b pixel", 32'(po1), 32'(exp16[15-i]));
      if (i == 8) chk("b2b ready after reload", 32'(i1.in_ready), 1);
      tick();
    end
    pe1 = 1'b0;
    chk("b2b valid after", 32'(pv1), 0);
    chk("b2b underrun", 32'(ur1), 0);

    // Underrun: strobe with nothing pending.
    pe1 = 1'b1;
    tick();
    pe1 = 1'b0;
    chk("underrun set", 32'(ur1), 1);
    chk("underrun pix_out", 32'(po1), 0);
    chk("underrun pix_valid", 32'(pv1), 0);
    tick(); tick(); tick();
    chk("underrun sticky", 32'(ur1), 1);

    // Reset mid-character with S1 full.
    do_reset();
    chk("reset clears underrun", 32'(ur1), 0);
    i1.in_valid = 1'b1; i1.in_code = 6'd1; i1.in_row = 4'd4; i1.in_inverse = 1'b0; pe1 = 1'b0;
    tick();
    i1.in_code = 6'd2; i1.in_row = 4'd3; pe1 = 1'b1;
    tick();
    i1.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("midreset pixel", 32'(po1), 0);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0; pe1 = 1'b0;
    chk("midreset pix_valid", 32'(pv1), 0);
    chk("midreset in_ready", 32'(i1.in_ready), 1);
    chk("midreset underrun", 32'(ur1), 0);
    chk("midreset pix_out", 32'(po1), 0);
    tick(); tick();
    chk("midreset S1 discarded", 32'(pv1), 0);
    run_char(1, 4, 1'b0, 1'b0, 8'b0001_0100, "after reset A row4");
    if (UL_ON) run_char(0, 10, 1'b0, 1'b1, 8'hFF, "underline");

    // PIX_REP=2 on dut2, strobe every other cycle.
    i2.in_valid = 1'b1; i2.in_code = 6'd9; i2.in_row = 4'd3; i2.in_inverse = 1'b0; i2.in_uline = 1'b0;
    pe2 = 1'b0;
    tick();
    i2.in_valid = 1'b0;
    exp16 = 16'b0000_0011_1111_0000;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      pe2 = (c % 2 == 0) && (n < 16);
      if (pe2 && pv2) begin
        chk("rep2 pixel", 32'(po2), 32'(exp16[15-n]));
        n++;
      end
      tick();
    end
    pe2 = 1'b0;
    chk("rep2 strobe count", 32'(n), 16);
    chk("rep2 valid after", 32'(pv2), 0);
    chk("rep2 underrun", 32'(ur2), 0);

    // Random traffic on both instances.
    for (int c = 0; c < 600; c++) begin
      i1.in_valid = ($urandom_range(0, 3) != 0);
      i1.in_code = 6'($urandom_range(0, 63)); i1.in_row = 4'($urandom_range(0, 15));
      i1.in_inverse = 1'($urandom_range(0, 1)); i1.in_uline = 1'($urandom_range(0, 1));
      i2.in_valid = ($urandom_range(0, 2) == 0);
      i2.in_code = 6'($urandom_range(0, 63)); i2.in_row = 4'($urandom_range(0, 15));
      i2.in_inverse = 1'($urandom_range(0, 1)); i2.in_uline = 1'($urandom_range(0, 1));
      pe1 = ($urandom_range(0, 4) != 0);
      pe2 = ($urandom_range(0, 2) != 0);
      tick();
    end
    i1.in_valid = 1'b0; i2.in_valid = 1'b0;
    pe1 = 1'b1; pe2 = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (q1.size() == 0 && q2.size() == 0 && !pv1 && !pv2) break;
      tick();
    end
    pe1 = 1'b0; pe2 = 1'b0;
    chk("drain dut1 queue", 32'(q1.size()), 0);
    chk("drain dut2 queue", 32'(q2.size()), 0);
    chk("drain dut1 valid", 32'(pv1), 0);
    chk("drain dut2 valid", 32'(pv2), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
